// File: rtl/cd_pkg.sv
// Shared types for the compression-engine request scheduler.
// Engine commands, engine responses, result status and FSM states.
package cd_pkg;

  typedef enum logic [1:0] {
    CMD_NOP        = 2'b00,
    CMD_COMPRESS   = 2'b01,
    CMD_DECOMPRESS = 2'b10,
    CMD_RESET      = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    RESP_NONE   = 2'b00,
    RESP_COMP   = 2'b01,
    RESP_DECOMP = 2'b10,
    RESP_ERR    = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_ENG_ERR = 2'b01,
    ST_TIMEOUT = 2'b10,
    ST_ILLEGAL = 2'b11
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP,
    S_GAP
  } state_e;

endpackage

// File: rtl/cd_req_fifo.sv
// Request FIFO: power-of-2 depth, wrapping pointers, occupancy count.
// Head entry is visible combinationally on rdata.
module cd_req_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  // Storage array; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  // Pointers and occupancy; simultaneous push and pop keep count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cd_request_scheduler.sv
// Queues compress/decompress requests and sequences them to the engine.
// One command in flight; a NOP gap always separates engine commands.
module cd_request_scheduler
  import cd_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [DATA_W-1:0] req_data,
  output logic [1:0]        command,
  output logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] compressed_in,
  input  logic [DATA_W-1:0] compressed_out,
  input  logic [DATA_W-1:0] decompressed_out,
  input  logic [1:0]        response,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [1:0]        res_status
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  state_e            state, state_n;
  logic [1:0]        cur_op, cur_op_n;
  logic [DATA_W-1:0] cur_data, cur_data_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [DATA_W-1:0] rdata_n;
  logic [1:0]        rstat_n;
  logic [DATA_W+1:0] head;
  logic              full;
  logic              empty;
  logic              pop;
  logic              busy;

  assign req_ready = !full;
  assign pop       = (state == S_IDLE) && !empty;

  cd_req_fifo #(
    .W     (DATA_W + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (req_valid && req_ready),
    .pop   (pop),
    .wdata ({req_op, req_data}),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  // Operands are only driven while a command is in flight.
  assign busy      = (state == S_ISSUE) || (state == S_WAIT);
  assign command   = busy ? cur_op : CMD_NOP;
  assign data_in   = (busy && cur_op == CMD_COMPRESS) ?
                     cur_data : '0;
  assign compressed_in = (busy && cur_op == CMD_DECOMPRESS) ?
                         cur_data : '0;
  assign res_valid = (state == S_RESP);

  // State, current request, wait counter and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cur_op     <= '0;
      cur_data   <= '0;
      cnt        <= '0;
      res_data   <= '0;
      res_status <= '0;
    end else begin
      state      <= state_n;
      cur_op     <= cur_op_n;
      cur_data   <= cur_data_n;
      cnt        <= cnt_n;
      res_data   <= rdata_n;
      res_status <= rstat_n;
    end
  end

  // Next-state logic and result capture.
  always_comb begin
    state_n    = state;
    cur_op_n   = cur_op;
    cur_data_n = cur_data;
    cnt_n      = cnt;
    rdata_n    = res_data;
    rstat_n    = res_status;
    unique case (state)
      S_IDLE: begin
        if (!empty) begin
          cur_op_n   = head[DATA_W+1:DATA_W];
          cur_data_n = head[DATA_W-1:0];
          cnt_n      = '0;
          if (head[DATA_W+1:DATA_W] == CMD_NOP) begin
            rdata_n = '0;
            rstat_n = ST_ILLEGAL;
            state_n = S_RESP;
          end else begin
            state_n = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        cnt_n   = '0;
        state_n = S_WAIT;
      end
      S_WAIT: begin
        if (cur_op == CMD_RESET) begin
          rdata_n = '0;
          rstat_n = ST_OK;
          state_n = S_RESP;
        end else begin
          case (resp_e'(response))
            RESP_COMP: begin
              rdata_n = compressed_out;
              rstat_n = ST_OK;
              state_n = S_RESP;
            end
            RESP_DECOMP: begin
              rdata_n = decompressed_out;
              rstat_n = ST_OK;
              state_n = S_RESP;
            end
            RESP_ERR: begin
              rdata_n = '0;
              rstat_n = ST_ENG_ERR;
              state_n = S_RESP;
            end
            default: begin
              if (cnt == CW'(TIMEOUT - 1)) begin
                rdata_n = '0;
                rstat_n = ST_TIMEOUT;
                state_n = S_RESP;
              end else begin
                cnt_n = cnt + CW'(1);
              end
            end
          endcase
        end
      end
      S_RESP: begin
        if (res_ready) state_n = S_GAP;
      end
      S_GAP: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cd_request_scheduler.sv
// Randomised bench with a transaction-level model of the scheduler.
// Bench also plays the engine, answering per a per-request plan.
module tb_cd_request_scheduler;
  import cd_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int TO    = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_op = '0;
  logic [DW-1:0] req_data = '0;
  logic [1:0]    command;
  logic [DW-1:0] data_in;
  logic [DW-1:0] compressed_in;
  logic [DW-1:0] compressed_out = '0;
  logic [DW-1:0] decompressed_out = '0;
  logic [1:0]    response = '0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [DW-1:0] res_data;
  logic [1:0]    res_status;

  cd_request_scheduler #(
    .DATA_W     (DW),
    .FIFO_DEPTH (DEPTH),
    .TIMEOUT    (TO)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_op           (req_op),
    .req_data         (req_data),
    .command          (command),
    .data_in          (data_in),
    .compressed_in    (compressed_in),
    .compressed_out   (compressed_out),
    .decompressed_out (decompressed_out),
    .response         (response),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .res_data         (res_data),
    .res_status       (res_status)
  );

  always #5 clk = ~clk;

  // One request plus the engine behaviour planned for it.
  // d: WAIT cycle (1-based) on which the engine answers.
  typedef struct {
    logic [1:0]    op;
    logic [DW-1:0] data;
    int            d;
    logic [1:0]    kind;
    logic [DW-1:0] v1;
    logic [DW-1:0] v2;
  } txn_t;

  txn_t q[$];
  int   eng_ptr = 0;
  int   res_ptr = 0;
  int   run_idx = 0;
  int   run_len = 0;
  bit   in_run = 0;
  bit   push_en = 0;
  int   push_pct = 40;
  int   rr_pct = 100;
  bit   pend = 0;
  txn_t pend_t;
  int   total = 0;
  int   bad = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic txn_t mk(logic [1:0] op, logic [DW-1:0] data,
                              int d, logic [1:0] kind,
                              logic [DW-1:0] v1, logic [DW-1:0] v2);
    txn_t t;
    t.op = op; t.data = data; t.d = d;
    t.kind = kind; t.v1 = v1; t.v2 = v2;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    int sel;
    logic [1:0] op;
    sel = $urandom_range(0, 9);
    if (sel == 0) op = 2'b00;
    else if (sel == 1) op = 2'b11;
    else if (sel < 6) op = 2'b01;
    else op = 2'b10;
    return mk(op, DW'($urandom), $urandom_range(1, 20),
              2'($urandom_range(1, 3)), DW'($urandom), DW'($urandom));
  endfunction

  function automatic logic [DW-1:0] exp_data(txn_t t);
    if (t.op == 2'b00 || t.op == 2'b11) return '0;
    if (t.d > TO) return '0;
    if (t.kind == 2'b01) return t.v1;
    if (t.kind == 2'b10) return t.v2;
    return '0;
  endfunction

  function automatic logic [1:0] exp_stat(txn_t t);
    if (t.op == 2'b00) return 2'b11;
    if (t.op == 2'b11) return 2'b00;
    if (t.d > TO) return 2'b10;
    if (t.kind == 2'b11) return 2'b01;
    return 2'b00;
  endfunction

  // ISSUE cycle plus the WAIT cycles until the answer or timeout.
  function automatic int exp_len(txn_t t);
    if (t.op == 2'b11) return 2;
    return 1 + ((t.d < TO) ? t.d : TO);
  endfunction

  task automatic cycle();
    txn_t t;
    @(negedge clk);
    if (command != 2'b00) begin
      if (!in_run) begin
        while (eng_ptr < q.size() && q[eng_ptr].op == 2'b00) eng_ptr++;
        if (eng_ptr >= q.size()) begin
          chk("spurious_cmd", 32'(command), 32'(0));
        end else begin
          run_idx = eng_ptr;
          eng_ptr++;
          in_run  = 1;
          run_len = 0;
        end
      end
      if (in_run) begin
        t = q[run_idx];
        run_len++;
        chk("command", 32'(command), 32'(t.op));
        chk("data_in", 32'(data_in),
            32'((t.op == 2'b01) ? t.data : '0));
        chk("compressed_in", 32'(compressed_in),
            32'((t.op == 2'b10) ? t.data : '0));
      end
    end else if (in_run) begin
      in_run = 0;
      chk("cmd_len", 32'(run_len), 32'(exp_len(q[run_idx])));
    end
    if (res_valid) begin
      if (res_ptr >= q.size()) begin
        chk("spurious_res", 32'(res_valid), 32'(0));
      end else begin
        chk("res_data", 32'(res_data), 32'(exp_data(q[res_ptr])));
        chk("res_status", 32'(res_status), 32'(exp_stat(q[res_ptr])));
      end
    end
    compressed_out   = DW'($urandom);
    decompressed_out = DW'($urandom);
    if (in_run) begin
      t = q[run_idx];
      if (run_len == 1) begin
        response = 2'($urandom_range(1, 3));
      end else if (t.op == 2'b11) begin
        response = 2'($urandom_range(0, 3));
      end else if (run_len - 1 == t.d) begin
        response         = t.kind;
        compressed_out   = t.v1;
        decompressed_out = t.v2;
      end else begin
        response = 2'b00;
      end
    end else begin
      response = ($urandom_range(0, 1) == 1) ?
                 2'($urandom_range(0, 3)) : 2'b00;
    end
    res_ready = ($urandom_range(0, 99) < rr_pct);
    if (res_valid && res_ready && res_ptr < q.size()) res_ptr++;
    if (pend) begin
      req_valid = 1'b1;
      req_op    = pend_t.op;
      req_data  = pend_t.data;
      if (req_ready) begin
        q.push_back(pend_t);
        pend = 0;
      end
    end else if (push_en && $urandom_range(0, 99) < push_pct) begin
      t = rand_txn();
      req_valid = 1'b1;
      req_op    = t.op;
      req_data  = t.data;
      if (req_ready) q.push_back(t);
    end else begin
      req_valid = 1'b0;
      req_op    = 2'($urandom);
      req_data  = DW'($urandom);
    end
  endtask

  task automatic push_one(txn_t t);
    pend_t = t;
    pend   = 1;
    for (int i = 0; i < 200 && pend; i++) cycle();
    chk("push_stall", 32'(pend), 32'(0));
    pend = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 600; i++) begin
      if (res_ptr == q.size() && !in_run && !pend) break;
      cycle();
    end
    chk("drain", 32'(res_ptr), 32'(q.size()));
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'(1));
    chk({tag, "_res_valid"}, 32'(res_valid), 32'(0));
    chk({tag, "_res_data"}, 32'(res_data), 32'(0));
    chk({tag, "_res_status"}, 32'(res_status), 32'(0));
    chk({tag, "_command"}, 32'(command), 32'(0));
    chk({tag, "_data_in"}, 32'(data_in), 32'(0));
    chk({tag, "_compressed_in"}, 32'(compressed_in), 32'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    req_valid = 1'b0;
    #1;
    chk_reset_outputs("rst");
    q.delete();
    eng_ptr = 0;
    res_ptr = 0;
    in_run  = 0;
    pend    = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #1;
    chk_reset_outputs("por");
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Basic compress with answer on the 2nd WAIT cycle.
    rr_pct = 100;
    push_one(mk(2'b01, 8'h41, 2, 2'b01, 8'h05, 8'h00));
    drain();

    // Fill the queue with the consumer stalled.
    rr_pct = 0;
    for (int i = 0; i < 5; i++)
      push_one(mk(2'b01, DW'(i + 1), 1, 2'b01, DW'(8'h80 + i), 8'h00));
    cycle();
    chk("full_ready", 32'(req_ready), 32'(0));
    rr_pct = 50;
    drain();

    // Silent engine times out, next request is normal.
    rr_pct = 100;
    push_one(mk(2'b10, 8'h05, 99, 2'b10, 8'h00, 8'h00));
    push_one(mk(2'b10, 8'h07, 3, 2'b10, 8'h00, 8'h3C));
    drain();

    // Illegal op and engine reset op.
    push_one(mk(2'b00, 8'h5A, 1, 2'b01, 8'h11, 8'h22));
    push_one(mk(2'b11, 8'h00, 1, 2'b01, 8'h00, 8'h00));
    drain();

    // Engine error with result held for several cycles.
    rr_pct = 0;
    push_one(mk(2'b01, 8'hFF, 1, 2'b11, 8'h99, 8'h99));
    for (int i = 0; i < 40 && !res_valid; i++) cycle();
    chk("err_valid", 32'(res_valid), 32'(1));
    repeat (3) cycle();
    rr_pct = 100;
    drain();

    // Reset while waiting with two entries queued.
    push_one(mk(2'b01, 8'h11, 99, 2'b01, 8'h00, 8'h00));
    push_one(mk(2'b10, 8'h22, 99, 2'b01, 8'h00, 8'h00));
    push_one(mk(2'b01, 8'h33, 99, 2'b01, 8'h00, 8'h00));
    for (int i = 0; i < 40 && !(in_run && run_len >= 3); i++) cycle();
    chk("in_wait", 32'(run_len >= 3), 32'(1));
    do_reset();
    repeat (10) cycle();
    chk("post_rst_ready", 32'(req_ready), 32'(1));
    chk("post_rst_cmd", 32'(command), 32'(0));

    // Random traffic.
    push_en  = 1;
    push_pct = 40;
    rr_pct   = 70;
    repeat (1500) cycle();
    push_en = 0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
